// File: rtl/se_scale_pkg.sv
// Shared types and constants for the squeeze-excite channel scaling stage.
package se_scale_pkg;

  // Two-phase operation: collect one gate per channel, then scale a frame.
  typedef enum logic {LOAD, SCALE} se_state_t;

  // Default gate format: 8.8 fixed point.
  localparam int SE_FRAC_BITS = 8;
  localparam int GATE_ONE     = 1 << SE_FRAC_BITS;
  localparam int RND_HALF     = 1 << (SE_FRAC_BITS - 1);

endpackage

// File: rtl/se_gate_mul.sv
// Combinational feature x gate multiply with round-half-up back to the feature format.
module se_gate_mul
  import se_scale_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = SE_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] feat,
  input  logic signed [DATA_WIDTH-1:0] gate,
  output logic signed [DATA_WIDTH-1:0] scaled
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] HALF = PW'(1 << (FRAC_BITS - 1));

  // Add half an LSB, shift arithmetically, keep the low word. The gate is
  // clamped to [0, 1.0] upstream, so the result always fits.
  function automatic logic signed [DATA_WIDTH-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = (p + HALF) >>> FRAC_BITS;
    return s[DATA_WIDTH-1:0];
  endfunction

  logic signed [PW-1:0] prod;

  // Full-precision signed product, then rounding.
  always_comb begin
    prod   = feat * gate;
    scaled = round_shift(prod);
  end

endmodule

// File: rtl/se_channel_scale.sv
// Squeeze-excite excitation: stores per-channel gates, then rescales a
// channel-interleaved feature stream by gate[ch] with a single output register.
module se_channel_scale
  import se_scale_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = SE_FRAC_BITS,
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_PIXELS   = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] gate_data,
  input  logic                         gate_valid,
  output logic                         gate_ready,
  input  logic signed [DATA_WIDTH-1:0] feat_data,
  input  logic                         feat_valid,
  output logic                         feat_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int CW = $clog2(NUM_CHANNELS);
  localparam int PXW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRAC_BITS);

  // Negative gates become 0 and anything above 1.0 becomes 1.0, so the
  // multiply can never grow a feature past its own magnitude.
  function automatic logic signed [DATA_WIDTH-1:0] clamp_gate(input logic signed [DATA_WIDTH-1:0] g);
    if (g < 0) return '0;
    else if (g > ONE) return ONE;
    else return g;
  endfunction

  se_state_t state, state_nxt;
  logic [CW-1:0]  g_idx;
  logic [CW-1:0]  ch_idx;
  logic [PXW-1:0] pix_idx;
  logic signed [DATA_WIDTH-1:0] gmem [NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] scaled;
  logic gate_acc, feat_acc, g_last, ch_last, pix_last, frame_last;

  assign gate_ready = (state == LOAD);
  assign feat_ready = (state == SCALE) & (~out_valid | out_ready);
  assign busy       = (state == SCALE) | out_valid;
  assign gate_acc   = gate_valid & gate_ready;
  assign feat_acc   = feat_valid & feat_ready;
  assign g_last     = (g_idx == CW'(NUM_CHANNELS - 1));
  assign ch_last    = (ch_idx == CW'(NUM_CHANNELS - 1));
  assign pix_last   = (pix_idx == PXW'(NUM_PIXELS - 1));
  assign frame_last = ch_last & pix_last;

  se_gate_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .feat  (feat_data),
    .gate  (gmem[ch_idx]),
    .scaled(scaled)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next state: a full gate set starts scaling, the last beat of a frame returns to loading.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (gate_acc && g_last) state_nxt = SCALE;
      SCALE:   if (feat_acc && frame_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Gate write index and channel/pixel position within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_idx   <= '0;
      ch_idx  <= '0;
      pix_idx <= '0;
    end else begin
      if (gate_acc) g_idx <= g_last ? '0 : g_idx + 1'b1;
      if (feat_acc) begin
        if (ch_last) begin
          ch_idx  <= '0;
          pix_idx <= pix_last ? '0 : pix_idx + 1'b1;
        end else begin
          ch_idx <= ch_idx + 1'b1;
        end
      end
    end
  end

  // Gate memory; contents are only meaningful after a full load, so no reset.
  always_ff @(posedge clk) begin
    if (gate_acc) gmem[g_idx] <= clamp_gate(gate_data);
  end

  // Output register: reload on accept, otherwise drain when downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (feat_acc) begin
      out_data  <= scaled;
      out_valid <= 1'b1;
      out_last  <= frame_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // One-cycle pulse following the handshake of the frame's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= out_valid & out_ready & out_last;
  end

endmodule
